// File: rtl/cnn_bn_relu_stream_18.sv
// Batch-norm + ReLU stage behind the 18th 3x3 conv layer.
// Loads (scale, bias) pairs per output channel from the weight stream. It then
// runs each channel-major pixel through a 3-stage multiply / add / saturate pipeline.
//
// Handshake: both input streams are valid-only (no ready). A word is consumed
// on every rising edge where its valid is high. pxl_out is meaningful only while
// valid_out is high, and holds its last value otherwise.
module cnn_bn_relu_stream_18 #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRAC_BITS       = 16,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_OUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  err,
    output logic                  state_dbg
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PXL_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int CH_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int WT_W       = CH_W + 1;
    localparam int PW         = 2 * DATA_WIDTH;

    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(2 * CHANNEL_NUM_OUT - 1);
    localparam logic [PXL_W-1:0] PXL_LAST = PXL_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_OUT - 1);

    // Saturation bounds of the output word, expressed at the full sum width.
    localparam logic signed [PW:0] SAT_MAX = {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [WT_W-1:0]   wt_cnt;
    logic [PXL_W-1:0]  pxl_cnt;
    logic [CH_W-1:0]   ch_cnt;

    logic [DATA_WIDTH-1:0] scale_mem [CHANNEL_NUM_OUT];
    logic [DATA_WIDTH-1:0] bias_mem  [CHANNEL_NUM_OUT];

    logic pxl_fire;
    logic reload;
    logic pxl_wrap;
    logic ch_wrap;
    logic mem_we;
    logic mem_odd;
    logic [CH_W-1:0] mem_idx;

    logic                         s1_valid;
    logic                         s1_last;
    logic signed [DATA_WIDTH-1:0] s1_x;
    logic signed [DATA_WIDTH-1:0] s1_scale;
    logic        [DATA_WIDTH-1:0] s1_bias;

    logic                         s2_valid;
    logic                         s2_last;
    logic signed [PW-1:0]         s2_p;
    logic        [DATA_WIDTH-1:0] s2_bias;

    logic signed [PW-1:0]         prod;
    logic signed [PW:0]           sum;
    logic        [DATA_WIDTH-1:0] sat_val;
    logic        [DATA_WIDTH-1:0] relu_val;

    assign state_dbg = (state == RUN);
    assign pxl_fire  = (state == RUN) && valid_in;
    assign pxl_wrap  = (pxl_cnt == PXL_LAST);
    assign ch_wrap   = (ch_cnt == CH_LAST);
    // A new parameter set may only start on an idle cycle at a frame boundary.
    assign reload    = (state == RUN) && valid_weight_in && !valid_in &&
                       (pxl_cnt == '0) && (ch_cnt == '0);

    // Parameter-store write port: sequential loading, or word 0 of a reload from RUN.
    always_comb begin
        mem_we  = 1'b0;
        mem_odd = 1'b0;
        mem_idx = '0;
        if (state == LOAD) begin
            mem_we  = valid_weight_in;
            mem_odd = wt_cnt[0];
            mem_idx = wt_cnt[WT_W-1:1];
        end else if (reload) begin
            mem_we  = 1'b1;
        end
    end

    // Parameter storage; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_odd) bias_mem[mem_idx]  <= weight_in;
            else         scale_mem[mem_idx] <= weight_in;
        end
    end

    // Control FSM: load counter, pixel/channel position and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LOAD;
            wt_cnt  <= '0;
            pxl_cnt <= '0;
            ch_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (valid_in) err <= 1'b1;
                    if (valid_weight_in) begin
                        if (wt_cnt == WT_LAST) begin
                            wt_cnt <= '0;
                            state  <= RUN;
                        end else begin
                            wt_cnt <= wt_cnt + WT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        if (pxl_wrap) begin
                            pxl_cnt <= '0;
                            ch_cnt  <= ch_wrap ? '0 : ch_cnt + CH_W'(1);
                        end else begin
                            pxl_cnt <= pxl_cnt + PXL_W'(1);
                        end
                    end
                    if (valid_weight_in) begin
                        if (reload) begin
                            state  <= LOAD;
                            wt_cnt <= WT_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // S1: capture the pixel with its channel's parameters and last-of-frame tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_scale <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= pxl_fire;
            if (pxl_fire) begin
                s1_x     <= pxl_in;
                s1_scale <= scale_mem[ch_cnt];
                s1_bias  <= bias_mem[ch_cnt];
                s1_last  <= pxl_wrap && ch_wrap;
            end
        end
    end

    assign prod = s1_x * s1_scale;

    // S2: full-width signed product, rescaled with an arithmetic (floor) shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_p     <= '0;
            s2_bias  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p    <= prod >>> FRAC_BITS;
                s2_bias <= s1_bias;
                s2_last <= s1_last;
            end
        end
    end

    // One extra bit of headroom keeps the bias add exact before saturation.
    always_comb begin
        sum = {s2_p[PW-1], s2_p} + {{(PW-DATA_WIDTH+1){s2_bias[DATA_WIDTH-1]}}, s2_bias};
        if (sum > SAT_MAX)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) sat_val = SAT_MIN[DATA_WIDTH-1:0];
        else                    sat_val = sum[DATA_WIDTH-1:0];
        relu_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
    end

    // S3: registered outputs; pxl_out only updates on a valid result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= s2_valid;
            frame_done <= s2_valid && s2_last;
            if (s2_valid) pxl_out <= relu_val;
        end
    end

endmodule

// File: tb/tb_cnn_bn_relu_stream_18.sv
// Testbench for cnn_bn_relu_stream_18 in the small configuration
// (IMAGE_SIZE = 4, CHANNEL_NUM_OUT = 2, Q16.16 data).
module tb_cnn_bn_relu_stream_18;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] scale;
        logic [DW-1:0] bias;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic          valid_weight_in = 1'b0;
    logic [DW-1:0] weight_in = '0;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          frame_done;
    logic          err;
    logic          state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] last_out = '0;

    vec_t vecs[10];

    cnn_bn_relu_stream_18 #(
        .DATA_WIDTH(32), .FRAC_BITS(16), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM_OUT(2)
    ) dut (
        .clk(clk), .reset(rst_n), .valid_in(valid_in), .pxl_in(pxl_in),
        .valid_weight_in(valid_weight_in), .weight_in(weight_in),
        .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done),
        .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_sb();
        exp_q.delete();
        exp_last_q.delete();
        exp_cyc_q.delete();
        last_out = '0;
    endtask

    // Asserts reset right now (asynchronously) and checks outputs before any clock edge.
    task automatic do_reset();
        valid_in        = 1'b0;
        valid_weight_in = 1'b0;
        rst_n           = 1'b0;
        flush_sb();
        #1;
        chk("rst_pxl_out", pxl_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state_dbg, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic px(input logic [DW-1:0] x, input logic [DW-1:0] e, input logic last);
        valid_in = 1'b1;
        pxl_in   = x;
        exp_q.push_back(e);
        exp_last_q.push_back(last);
        exp_cyc_q.push_back(cyc + 3);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic px_wt(input logic [DW-1:0] x, input logic [DW-1:0] e, input logic last,
                         input logic [DW-1:0] w);
        valid_weight_in = 1'b1;
        weight_in       = w;
        px(x, e, last);
        valid_weight_in = 1'b0;
    endtask

    task automatic px_drop(input logic [DW-1:0] x);
        valid_in = 1'b1;
        pxl_in   = x;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wt(input logic [DW-1:0] w);
        valid_weight_in = 1'b1;
        weight_in       = w;
        tick();
        valid_weight_in = 1'b0;
    endtask

    task automatic load4(input logic [DW-1:0] s0, input logic [DW-1:0] b0,
                         input logic [DW-1:0] s1, input logic [DW-1:0] b1);
        wt(s0);
        wt(b0);
        wt(s1);
        wt(b1);
    endtask

    task automatic drain();
        repeat (6) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic          el;
        int            ec;
        if (rst_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%08h, expected no valid_out (cycle %0d)",
                             pxl_out, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("pxl_out", pxl_out, e);
                    chk("frame_done", frame_done, el);
                    chk("latency_cycle", cyc, ec);
                end
                last_out = pxl_out;
            end else begin
                chk("idle_frame_done", frame_done, 0);
                chk("hold_pxl_out", pxl_out, last_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] xv;
        logic [DW-1:0] ev;

        // x, scale, bias, expected y (all Q16.16)
        vecs[0] = '{32'h00020000, 32'h00010000, 32'h00008000, 32'h00028000}; // 2.0*1+0.5
        vecs[1] = '{32'hFFFD0000, 32'h00010000, 32'h00008000, 32'h00000000}; // -2.5 -> 0
        vecs[2] = '{32'h7FFF0000, 32'h00020000, 32'h00000000, 32'h7FFFFFFF}; // product sat
        vecs[3] = '{32'h00018000, 32'hFFFF0000, 32'h00040000, 32'h00028000}; // -1.5+4
        vecs[4] = '{32'hFFFFFFFF, 32'h00008000, 32'h00000002, 32'h00000001}; // floor shift
        vecs[5] = '{32'h7FFF0000, 32'h00010000, 32'h7FFFFFFF, 32'h7FFFFFFF}; // bias add sat
        vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000}; // big negative
        vecs[7] = '{32'h7FFFFFFF, 32'h00010000, 32'h00000000, 32'h7FFFFFFF}; // exact max
        vecs[8] = '{32'h00000001, 32'h00008000, 32'h00000000, 32'h00000000}; // tiny truncates
        vecs[9] = '{32'h00030000, 32'h00010000, 32'hFFFF0000, 32'h00020000}; // negative bias

        #1;
        do_reset();

        // Single-pixel vectors through channel 0
        for (int i = 0; i < 10; i++) begin
            do_reset();
            load4(vecs[i].scale, vecs[i].bias, 32'h00010000, 32'h00000000);
            chk("load_to_run", state_dbg, 1);
            px(vecs[i].x, vecs[i].exp, 1'b0);
            drain();
        end

        // Channel switching, frame_done, frame wrap, then reload at frame boundary
        do_reset();
        load4(32'h00010000, 32'h00008000, 32'h00008000, 32'h00000000);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) px(32'h00040000, 32'h00048000, 1'b0);
            for (int i = 0; i < 4; i++) px(32'h00040000, 32'h00020000, i == 3);
        end
        wt(32'h00020000);
        chk("reload_state_load", state_dbg, 0);
        chk("reload_no_err", err, 0);
        wt(32'h00000000);
        wt(32'h00010000);
        chk("reload_still_load", state_dbg, 0);
        wt(32'h00010000);
        chk("reload_back_run", state_dbg, 1);
        for (int i = 0; i < 4; i++) px(32'h00040000, 32'h00080000, 1'b0);
        for (int i = 0; i < 4; i++) px(32'h00040000, 32'h00050000, i == 3);
        drain();
        chk("reload_err_clear", err, 0);

        // Pixel during LOAD is dropped and sets a sticky error
        do_reset();
        px_drop(32'h00010000);
        chk("load_pixel_err", err, 1);
        chk("load_pixel_state", state_dbg, 0);
        load4(32'h00010000, 32'h00000000, 32'h00008000, 32'h00000000);
        chk("err_sticky", err, 1);
        drain();

        // Weight word together with a pixel at frame start: ignored, pixel processed
        do_reset();
        load4(32'h00010000, 32'h00000000, 32'h00008000, 32'h00000000);
        for (int i = 0; i < 8; i++) begin
            xv = 32'(i + 1) << 16;
            ev = (i < 4) ? xv : (xv >> 1);
            if (i == 0) begin
                px_wt(xv, ev, 1'b0, 32'hDEADBEEF);
                chk("same_cycle_wt_err", err, 1);
                chk("same_cycle_wt_state", state_dbg, 1);
            end else begin
                px(xv, ev, i == 7);
            end
        end
        drain();

        // Weight word mid-frame: ignored, stream unaffected
        do_reset();
        load4(32'h00010000, 32'h00000000, 32'h00008000, 32'h00000000);
        for (int i = 0; i < 8; i++) begin
            xv = 32'(i + 1) << 16;
            ev = (i < 4) ? xv : (xv >> 1);
            if (i == 2) begin
                wt(32'h12345678);
                chk("mid_frame_wt_err", err, 1);
                chk("mid_frame_wt_state", state_dbg, 1);
            end
            px(xv, ev, i == 7);
        end
        drain();
        chk("mid_frame_err_sticky", err, 1);

        // Reset mid-frame, then pixels dropped until a full reload
        do_reset();
        load4(32'h00010000, 32'h00000000, 32'h00008000, 32'h00000000);
        for (int i = 0; i < 4; i++) px(32'h00030000, 32'h00030000, 1'b0);
        tick();
        chk("pre_reset_valid", valid_out, 1);
        do_reset();
        px_drop(32'h00050000);
        chk("post_reset_drop_err", err, 1);
        wt(32'h00010000);
        wt(32'h00000000);
        wt(32'h00010000);
        px_drop(32'h00050000);
        chk("partial_reload_state", state_dbg, 0);
        wt(32'h00000000);
        chk("full_reload_state", state_dbg, 1);
        px(32'h00050000, 32'h00050000, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
